dmem_arbiter: RTL

- Shares the single data-memory port between two requesters: the core's memory stage and a debug/inspect port used to read or write any data-memory location.
- Handles a variable-latency memory with a req/ready handshake.
- Drives the pipeline-wide STALL signal that is currently tied low in the core.
- Sits between the core's MEM stage (dmem_addr/dmem_dataout/dmem_rw/dmem_datain) and the data memory.

---
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core MEM stage and the debug port; grant to mem_req is 1 cycle, min access 2 cycles.
// Backpressure: core held via combinational core_stall, debug via level dbg_req until dbg_ack; stuck memory aborts after MAX_WAIT.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        timeout_err
);

  localparam int SCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  localparam logic [SCW-1:0] STARVE_ONE = SCW'(1);
  localparam logic [7:0]     WAIT_MAX   = 8'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CORE_BUSY = 2'd1,
    DBG_BUSY  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SCW-1:0]  starve_cnt;
  logic [7:0]      wait_cnt;
  logic [31:0]     core_rdata_q;
  logic [31:0]     resp_data;
  logic            busy;
  logic            starved;
  logic            abort;
  logic            completing;
  logic            core_done;
  logic            dbg_done;
  logic            grant_core;
  logic            grant_dbg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A ready arriving in the same cycle as the wait limit wins over the abort.
  always_comb begin
    state_nxt  = state;
    grant_core = 1'b0;
    grant_dbg  = 1'b0;
    busy       = (state != IDLE);
    starved    = (starve_cnt >= STARVE_MAX);
    abort      = busy && !mem_ready && (wait_cnt == WAIT_MAX);
    completing = busy && (mem_ready || abort);
    core_done  = (state == CORE_BUSY) && completing;
    dbg_done   = (state == DBG_BUSY) && completing;
    resp_data  = abort ? 32'h0000_0000 : mem_rdata;
    case (state)
      IDLE: begin
        if (dbg_req && (!core_req || starved)) begin
          grant_dbg = 1'b1;
          state_nxt = DBG_BUSY;
        end else if (core_req) begin
          grant_core = 1'b1;
          state_nxt  = CORE_BUSY;
        end
      end
      CORE_BUSY, DBG_BUSY: begin
        if (completing) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req    = busy;
  assign core_stall = core_req && !core_done;
  assign core_rdata = core_done ? resp_data : core_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      wait_cnt     <= 8'h0;
      starve_cnt   <= '0;
      timeout_err  <= 1'b0;
      dbg_ack      <= 1'b0;
      dbg_rdata    <= 32'h0;
      core_rdata_q <= 32'h0;
    end else begin
      dbg_ack <= dbg_done;

      if (grant_core) begin
        mem_we    <= core_we;
        mem_addr  <= core_addr;
        mem_wdata <= core_wdata;
      end else if (grant_dbg) begin
        mem_we    <= dbg_we;
        mem_addr  <= dbg_addr;
        mem_wdata <= dbg_wdata;
      end

      if (grant_core || grant_dbg) begin
        wait_cnt <= 8'h0;
      end else if (busy && !completing) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Bubble cycles with dbg_req still high keep the count alive.
      if (grant_dbg) begin
        starve_cnt <= '0;
      end else if ((state == IDLE) && !dbg_req) begin
        starve_cnt <= '0;
      end else if (grant_core && dbg_req && !starved) begin
        starve_cnt <= starve_cnt + STARVE_ONE;
      end

      if (abort) begin
        timeout_err <= 1'b1;
      end
      if (dbg_done) begin
        dbg_rdata <= resp_data;
      end
      if (core_done) begin
        core_rdata_q <= resp_data;
      end
    end
  end

endmodule
